// File: rtl/sram_axi_pkg.sv
// Shared IDs, size encodings, write-buffer entry layout and strobe helper for the SRAM-to-AXI3 bridge.
package sram_axi_pkg;

  localparam int unsigned INST_ID = 0;
  localparam int unsigned DATA_ID = 1;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } wentry_t;

  // Reserved size 3 falls into the word case.
  function automatic logic [3:0] strb_from_size(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = 4'b0011 << off;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side bundle between the bridge (master) and the crossbar (slave).
interface sram_axi_bridge_if #(parameter int ID_W = 4);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/sram_axi_wbuf.sv
// Posted write buffer: alloc -> issue (AW+W, independent handshakes) -> retire (on B); valids rise the cycle after alloc.
// Backpressure: full_o blocks allocation; issue holds the entry until both AW and W have handshaken.
module sram_axi_wbuf
  import sram_axi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             alloc_i,
  input  wentry_t          alloc_ent_i,
  input  logic             retire_i,
  input  logic [29:0]      cmp_word_i,
  input  logic             aw_rdy_i,
  input  logic             w_rdy_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEPTH-1:0] match_o,
  output wentry_t          iss_ent_o,
  output logic             aw_vld_o,
  output logic             w_vld_o
);
  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   alloc_q, alloc_d, iss_q, iss_d, ret_q, ret_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  wentry_t          mem_q [DEPTH];
  logic             pend, aw_hs, w_hs, iss_adv;

  assign full_o    = (alloc_q - ret_q) == (PTR_W+1)'(DEPTH);
  assign empty_o   = alloc_q == ret_q;
  assign pend      = iss_q != alloc_q;
  assign iss_ent_o = mem_q[iss_q[PTR_W-1:0]];
  assign aw_vld_o  = pend && !aw_done_q;
  assign w_vld_o   = pend && !w_done_q;
  assign aw_hs     = aw_vld_o && aw_rdy_i;
  assign w_hs      = w_vld_o && w_rdy_i;
  assign iss_adv   = pend && (aw_done_q || aw_hs) && (w_done_q || w_hs);

  always_comb begin
    alloc_d   = alloc_q + {{PTR_W{1'b0}}, alloc_i};
    ret_d     = ret_q + {{PTR_W{1'b0}}, retire_i};
    iss_d     = iss_q + {{PTR_W{1'b0}}, iss_adv};
    aw_done_d = iss_adv ? 1'b0 : (aw_done_q || aw_hs);
    w_done_d  = iss_adv ? 1'b0 : (w_done_q || w_hs);
    vld_d     = vld_q;
    if (retire_i) vld_d[ret_q[PTR_W-1:0]] = 1'b0;
    if (alloc_i)  vld_d[alloc_q[PTR_W-1:0]] = 1'b1;
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = vld_q[i] && (mem_q[i].addr[31:2] == cmp_word_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alloc_q   <= '0;
      iss_q     <= '0;
      ret_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      vld_q     <= '0;
    end else begin
      alloc_q   <= alloc_d;
      iss_q     <= iss_d;
      ret_q     <= ret_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      vld_q     <= vld_d;
      if (alloc_i) mem_q[alloc_q[PTR_W-1:0]] <= alloc_ent_i;
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Two-port SRAM-style to AXI3 bridge; addr_ok same cycle, min 2-cycle req-to-data_ok; SRAM_AXI_RAW_CHECK_EN narrows RAW stalls to word matches.
// Backpressure: reads held by AR register, per-port outstanding limit and RAW guard; writes held only by a full buffer.
module sram_axi_bridge
  import sram_axi_pkg::*;
#(
  parameter int RD_OUTSTANDING = 2,
  parameter int WBUF_DEPTH     = 2,
  parameter int ID_W           = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  input  logic [1:0]  inst_size_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic        data_resp_wr_o,
  output logic [31:0] data_rdata_o,
  sram_axi_bridge_if.master axi
);
  localparam int CNT_W = $clog2(RD_OUTSTANDING + 1);
  localparam logic [ID_W-1:0] IID = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DID = ID_W'(DATA_ID);

  logic             ar_vld_q, ar_vld_d;
  logic [ID_W-1:0]  ar_id_q, ar_id_d;
  logic [31:0]      ar_addr_q, ar_addr_d;
  logic [2:0]       ar_size_q, ar_size_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d, data_cnt_q, data_cnt_d;

  logic r_hs, b_hs, inst_r, data_r, ar_free, raw_block;
  logic inst_rd_ok, data_rd_ok, data_wr_ok;
  logic wb_full, wb_empty;
  logic [WBUF_DEPTH-1:0] wb_match;
  wentry_t wb_new, wb_iss;

  assign r_hs    = axi.rvalid && axi.rready;
  assign b_hs    = axi.bvalid && axi.bready;
  assign inst_r  = r_hs && (axi.rid == IID);
  assign data_r  = r_hs && (axi.rid == DID);
  assign ar_free = !ar_vld_q || axi.arready;

`ifdef SRAM_AXI_RAW_CHECK_EN
  logic empty_unused;
  assign empty_unused = wb_empty;
  assign raw_block    = |wb_match;
`else
  logic match_unused;
  assign match_unused = ^wb_match;
  assign raw_block    = !wb_empty;
`endif

  // A returning R beat frees its slot within the same cycle.
  assign data_rd_ok = resetn && data_req_i && !data_wr_i && ar_free && !raw_block &&
                      ((data_cnt_q < CNT_W'(RD_OUTSTANDING)) || data_r);
  assign inst_rd_ok = resetn && inst_req_i && ar_free && !data_rd_ok &&
                      ((inst_cnt_q < CNT_W'(RD_OUTSTANDING)) || inst_r);
  assign data_wr_ok = resetn && data_req_i && data_wr_i && (!wb_full || b_hs);

  always_comb begin
    ar_vld_d   = ar_vld_q && !axi.arready;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    if (data_rd_ok) begin
      ar_vld_d  = 1'b1;
      ar_id_d   = DID;
      ar_addr_d = data_addr_i;
      ar_size_d = {1'b0, data_size_i};
    end else if (inst_rd_ok) begin
      ar_vld_d  = 1'b1;
      ar_id_d   = IID;
      ar_addr_d = inst_addr_i;
      ar_size_d = {1'b0, inst_size_i};
    end
    inst_cnt_d = inst_cnt_q + CNT_W'(inst_rd_ok) - CNT_W'(inst_r);
    data_cnt_d = data_cnt_q + CNT_W'(data_rd_ok) - CNT_W'(data_r);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_vld_q   <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      ar_vld_q   <= ar_vld_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  assign wb_new = '{addr: data_addr_i, wdata: data_wdata_i, size: data_size_i};

  sram_axi_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk         (clk),
    .resetn      (resetn),
    .alloc_i     (data_wr_ok),
    .alloc_ent_i (wb_new),
    .retire_i    (b_hs),
    .cmp_word_i  (data_addr_i[31:2]),
    .aw_rdy_i    (axi.awready),
    .w_rdy_i     (axi.wready),
    .full_o      (wb_full),
    .empty_o     (wb_empty),
    .match_o     (wb_match),
    .iss_ent_o   (wb_iss),
    .aw_vld_o    (axi.awvalid),
    .w_vld_o     (axi.wvalid)
  );

  assign inst_addr_ok_o = inst_rd_ok;
  assign data_addr_ok_o = data_rd_ok || data_wr_ok;
  assign inst_data_ok_o = inst_r;
  assign data_data_ok_o = data_r || b_hs;
  assign data_resp_wr_o = b_hs;
  assign inst_rdata_o   = axi.rdata;
  assign data_rdata_o   = axi.rdata;

  assign axi.arid    = ar_id_q;
  assign axi.araddr  = ar_addr_q;
  assign axi.arsize  = ar_size_q;
  assign axi.arvalid = ar_vld_q;
  assign axi.arlen   = 4'd0;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.rready  = resetn;
  // A data read beat owns the data response this cycle, so B waits one.
  assign axi.bready  = resetn && !(axi.rvalid && (axi.rid == DID));

  assign axi.awid    = DID;
  assign axi.awaddr  = wb_iss.addr;
  assign axi.awsize  = {1'b0, wb_iss.size};
  assign axi.awlen   = 4'd0;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wid     = DID;
  assign axi.wdata   = wb_iss.wdata;
  assign axi.wstrb   = strb_from_size(wb_iss.size, wb_iss.addr[1:0]);
  assign axi.wlast   = 1'b1;

  logic axi_unused;
  assign axi_unused = ^{axi.rresp, axi.rlast, axi.bresp, axi.bid};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a small AXI slave model (queued R/B, gateable per channel).
module tb_sram_axi_bridge;

`ifdef SRAM_AXI_RAW_CHECK_EN
  localparam bit RAW_EN = 1'b1;
`else
  localparam bit RAW_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [1:0]  inst_size;
  logic        data_req, data_wr, data_addr_ok, data_data_ok, data_resp_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  bit          r_en, b_en;
  int          n_vec, n_err;

  sram_axi_bridge_if #(.ID_W(4)) axi ();

  sram_axi_bridge #(.RD_OUTSTANDING(2), .WBUF_DEPTH(2), .ID_W(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req_i     (inst_req),
    .inst_addr_i    (inst_addr),
    .inst_size_i    (inst_size),
    .inst_addr_ok_o (inst_addr_ok),
    .inst_data_ok_o (inst_data_ok),
    .inst_rdata_o   (inst_rdata),
    .data_req_i     (data_req),
    .data_wr_i      (data_wr),
    .data_size_i    (data_size),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_addr_ok_o (data_addr_ok),
    .data_data_ok_o (data_data_ok),
    .data_resp_wr_o (data_resp_wr),
    .data_rdata_o   (data_rdata),
    .axi            (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic dreq(input logic req, input logic wr, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    data_req   = req;
    data_wr    = wr;
    data_size  = sz;
    data_addr  = a;
    data_wdata = d;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h1FC0_0000) ? 32'h3C08_0001 : (a ^ 32'h5A5A_0000);
  endfunction

  // Slave: R one cycle after AR, B one cycle after both AW and W; r_en/b_en hold the channels.
  initial begin : slave
    logic [3:0]  rq_id [$];
    logic [31:0] rq_dat[$];
    int          bq, aw_pend, w_pend;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    bq = 0; aw_pend = 0; w_pend = 0;
    axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b1;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs   = axi.arvalid && axi.arready;
      ar_id   = axi.arid;
      ar_addr = axi.araddr;
      r_hs    = axi.rvalid && axi.rready;
      aw_hs   = axi.awvalid && axi.awready;
      w_hs    = axi.wvalid && axi.wready;
      b_hs    = axi.bvalid && axi.bready;
      @(posedge clk);
      #3;
      if (!resetn) begin
        rq_id.delete(); rq_dat.delete();
        bq = 0; aw_pend = 0; w_pend = 0;
      end else begin
        if (r_hs && rq_id.size() != 0) begin
          void'(rq_id.pop_front());
          void'(rq_dat.pop_front());
        end
        if (ar_hs) begin
          rq_id.push_back(ar_id);
          rq_dat.push_back(mem_rd(ar_addr));
        end
        if (b_hs && bq > 0) bq--;
        if (aw_hs) aw_pend++;
        if (w_hs) w_pend++;
        while (aw_pend > 0 && w_pend > 0) begin
          bq++; aw_pend--; w_pend--;
        end
      end
      axi.rvalid = r_en && rq_id.size() != 0;
      axi.rid    = (rq_id.size() != 0) ? rq_id[0] : 4'd0;
      axi.rdata  = (rq_dat.size() != 0) ? rq_dat[0] : 32'd0;
      axi.bvalid = b_en && bq > 0;
      axi.bid    = 4'd1;
    end
  end

  initial begin : main
    int n, st, b_cyc, acc10, nrd, n_wr;
    bit rd_acc;
    logic [31:0] last_rd;
    n_vec = 0; n_err = 0;
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0; inst_size = 2'd2;
    dreq(1'b1, 1'b1, 2'd2, 32'h8000_0000, 32'h0);
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    r_en = 1'b1; b_en = 1'b1;
    repeat (3) cyc();

    // Reset: requests presented but nothing accepted or driven.
    smp();
    chk("rst inst_addr_ok", inst_addr_ok, 0);
    chk("rst data_addr_ok", data_addr_ok, 0);
    chk("rst data_data_ok", data_data_ok, 0);
    chk("rst arvalid", axi.arvalid, 0);
    chk("rst awvalid", axi.awvalid, 0);
    chk("rst wvalid", axi.wvalid, 0);
    chk("rst rready", axi.rready, 0);
    chk("rst bready", axi.bready, 0);
    cyc();
    inst_req = 1'b0; dreq(1'b0, 1'b0, 2'd2, 32'h0, 32'h0);
    resetn = 1'b1;
    cyc();

    // Single inst read, zero-wait slave.
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2;
    smp();
    chk("t1 c0 addr_ok", inst_addr_ok, 1);
    chk("t1 c0 arvalid", axi.arvalid, 0);
    cyc();
    inst_req = 1'b0;
    smp();
    chk("t1 c1 arvalid", axi.arvalid, 1);
    chk("t1 c1 araddr", axi.araddr, 32'h1FC0_0000);
    chk("t1 c1 arid", axi.arid, 0);
    chk("t1 c1 arsize", axi.arsize, 2);
    chk("t1 c1 arburst", axi.arburst, 1);
    chk("t1 c1 inst_data_ok", inst_data_ok, 0);
    cyc();
    smp();
    chk("t1 c2 inst_data_ok", inst_data_ok, 1);
    chk("t1 c2 rdata", inst_rdata, 32'h3C08_0001);
    cyc();

    // Outstanding limit: third read waits for the first R beat, accepted in that cycle.
    r_en = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0004;
    smp(); chk("t2 rd0 addr_ok", inst_addr_ok, 1); cyc();
    smp(); chk("t2 rd1 addr_ok", inst_addr_ok, 1); cyc();
    smp(); chk("t2 rd2 blocked a", inst_addr_ok, 0); cyc();
    smp(); chk("t2 rd2 blocked b", inst_addr_ok, 0); cyc();
    r_en = 1'b1;
    smp();
    chk("t2 first R data_ok", inst_data_ok, 1);
    chk("t2 rd2 accepted on R", inst_addr_ok, 1);
    cyc();
    inst_req = 1'b0;
    smp();
    chk("t2 second R data_ok", inst_data_ok, 1);
    chk("t2 second R rdata", inst_rdata, 32'h459A_0004);
    cyc();
    n = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (inst_data_ok) n++;
      cyc();
    end
    chk("t2 third R count", n, 1);

    // Byte write at offset 3.
    dreq(1'b1, 1'b1, 2'd0, 32'h8000_1003, 32'h0000_00AB);
    smp(); chk("t3 c0 addr_ok", data_addr_ok, 1); cyc();
    dreq(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    smp();
    chk("t3 c1 awvalid", axi.awvalid, 1);
    chk("t3 c1 wvalid", axi.wvalid, 1);
    chk("t3 c1 awaddr", axi.awaddr, 32'h8000_1003);
    chk("t3 c1 awsize", axi.awsize, 0);
    chk("t3 c1 wstrb", axi.wstrb, 4'b1000);
    chk("t3 c1 wdata", axi.wdata, 32'h0000_00AB);
    chk("t3 c1 awid", axi.awid, 1);
    chk("t3 c1 wlast", axi.wlast, 1);
    cyc();
    smp();
    chk("t3 c2 data_ok", data_data_ok, 1);
    chk("t3 c2 resp_wr", data_resp_wr, 1);
    cyc();
    smp(); chk("t3 c3 data_ok idle", data_data_ok, 0); cyc();

    // Full buffer with AW stalled; B in the same cycle frees a slot for the waiting write.
    axi.awready = 1'b0;
    dreq(1'b1, 1'b1, 2'd2, 32'h8000_0100, 32'h1111_1111);
    smp(); chk("t4 wrA addr_ok", data_addr_ok, 1); cyc();
    dreq(1'b1, 1'b1, 2'd1, 32'h8000_0104, 32'h0000_2222);
    smp(); chk("t4 wrB addr_ok", data_addr_ok, 1); cyc();
    dreq(1'b1, 1'b1, 2'd2, 32'h8000_0108, 32'h3333_3333);
    smp();
    chk("t4 wrC full", data_addr_ok, 0);
    chk("t4 awvalid held", axi.awvalid, 1);
    chk("t4 wvalid dropped", axi.wvalid, 0);
    cyc();
    smp(); chk("t4 wrC full b", data_addr_ok, 0); cyc();
    axi.awready = 1'b1;
    smp();
    chk("t4 awaddr A", axi.awaddr, 32'h8000_0100);
    chk("t4 wrC still full", data_addr_ok, 0);
    cyc();
    smp();
    chk("t4 B(A) data_ok", data_data_ok, 1);
    chk("t4 B(A) resp_wr", data_resp_wr, 1);
    chk("t4 wrC on B", data_addr_ok, 1);
    chk("t4 awaddr B", axi.awaddr, 32'h8000_0104);
    chk("t4 wstrb B", axi.wstrb, 4'b0011);
    chk("t4 awsize B", axi.awsize, 1);
    cyc();
    dreq(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    smp();
    chk("t4 B(B) data_ok", data_data_ok, 1);
    chk("t4 B(B) resp_wr", data_resp_wr, 1);
    chk("t4 awaddr C", axi.awaddr, 32'h8000_0108);
    cyc();
    smp(); chk("t4 B(C) data_ok", data_data_ok, 1); cyc();
    repeat (2) cyc();

    // RAW guard with B held.
    b_en = 1'b0;
    dreq(1'b1, 1'b1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D);
    smp(); chk("t5 wr addr_ok", data_addr_ok, 1); cyc();
    dreq(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0);
    smp(); chk("t5 rd10 blocked a", data_addr_ok, 0); cyc();
    smp(); chk("t5 rd10 blocked b", data_addr_ok, 0); cyc();
    rd_acc = 1'b0; nrd = 0; n_wr = 0;
    for (int k = 0; k < 4; k++) begin
      dreq(!rd_acc, 1'b0, 2'd2, 32'h8000_0020, 32'h0);
      smp();
      if (data_addr_ok) rd_acc = 1'b1;
      if (data_data_ok && !data_resp_wr) nrd++;
      if (data_data_ok && data_resp_wr) n_wr++;
      cyc();
    end
    chk("t5 rd20 before B", rd_acc, RAW_EN ? 1 : 0);
    chk("t5 rd20 resp before B", nrd, RAW_EN ? 1 : 0);
    chk("t5 no B while held", n_wr, 0);
    b_en = 1'b1;
    st = rd_acc ? 1 : 0; b_cyc = -1; acc10 = -1; nrd = 0; last_rd = 32'h0;
    for (int k = 0; k < 8; k++) begin
      dreq(st < 2, 1'b0, 2'd2, (st == 0) ? 32'h8000_0020 : 32'h8000_0010, 32'h0);
      smp();
      if (data_data_ok && data_resp_wr && b_cyc < 0) b_cyc = k;
      if (data_data_ok && !data_resp_wr) begin
        nrd++;
        last_rd = data_rdata;
      end
      if (data_addr_ok) begin
        if (st == 1) acc10 = k;
        st++;
      end
      cyc();
    end
    dreq(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("t5 B cycle", b_cyc, 0);
    chk("t5 rd10 accept cycle", acc10, RAW_EN ? 1 : 2);
    chk("t5 reads after B", nrd, RAW_EN ? 1 : 2);
    chk("t5 rd10 rdata", last_rd, 32'hDA5A_0010);

    // R(id 1) and B together: read response first, B next cycle.
    r_en = 1'b0; b_en = 1'b0;
    dreq(1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'h0);
    smp(); chk("t6 rd addr_ok", data_addr_ok, 1); cyc();
    dreq(1'b1, 1'b1, 2'd2, 32'h8000_0080, 32'h1234_5678);
    smp(); chk("t6 wr addr_ok", data_addr_ok, 1); cyc();
    dreq(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (2) cyc();
    r_en = 1'b1; b_en = 1'b1;
    smp();
    chk("t6 bready low", axi.bready, 0);
    chk("t6 rd data_ok", data_data_ok, 1);
    chk("t6 rd resp_wr", data_resp_wr, 0);
    chk("t6 rd rdata", data_rdata, 32'hDA5A_0040);
    cyc();
    smp();
    chk("t6 bready high", axi.bready, 1);
    chk("t6 wr data_ok", data_data_ok, 1);
    chk("t6 wr resp_wr", data_resp_wr, 1);
    cyc();
    smp(); chk("t6 idle data_ok", data_data_ok, 0); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
